audio_route_fader: RTL and testbench

Click-free output router between the band-pass DA filter and the audio DAC. It replaces the hard switch-driven selection between muted, dry (ADC pass-through) and wet (filtered) audio. On a mode change it ramps per-source gains linearly, one step per audio sample, so the DAC never sees a step discontinuity. Runs entirely in the system `clk` domain. Sample strobes come from the ADC `done` pulse; switch levels come from the debounced sw0/sw1.

---
 rtl/audio_pkg.sv | 35 +++
 rtl/audio_route_fader_if.sv | 23 ++
 rtl/audio_mix_channel.sv | 68 ++++++
 rtl/audio_route_fader.sv | 105 ++++++++++
 tb/tb_audio_route_fader.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio output router: mode and fader state
// encodings, sample width and stereo packing slices.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  // Stereo packing: left channel in the upper half, right in the lower half
  localparam int unsigned L_HI = 31;
  localparam int unsigned L_LO = 16;
  localparam int unsigned R_HI = 15;
  localparam int unsigned R_LO = 0;

  typedef enum logic [1:0] {
    MODE_MUTE = 2'd0,
    MODE_DRY  = 2'd1,
    MODE_WET  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    STEADY_MUTE = 2'd0,
    STEADY_DRY  = 2'd1,
    STEADY_WET  = 2'd2,
    FADING      = 2'd3
  } fader_state_e;

  // {sw1,sw0}: 01 selects dry, 11 selects wet, anything with sw0 low mutes
  function automatic mode_e decode_mode(input logic [1:0] sw);
    case (sw)
      2'b01:   return MODE_DRY;
      2'b11:   return MODE_WET;
      default: return MODE_MUTE;
    endcase
  endfunction

endpackage

// File: rtl/audio_route_fader_if.sv
// Sample/switch inputs and mixed DAC outputs of the audio output router.
interface audio_route_fader_if;

  logic        sampleValid;
  logic [31:0] dryIn;
  logic [31:0] wetIn;
  logic        sw0;
  logic        sw1;
  logic [31:0] dacOut;
  logic        dacValid;
  logic        fadeBusy;

  modport master (
    output sampleValid, dryIn, wetIn, sw0, sw1,
    input  dacOut, dacValid, fadeBusy
  );

  modport slave (
    input  sampleValid, dryIn, wetIn, sw0, sw1,
    output dacOut, dacValid, fadeBusy
  );

endinterface

// File: rtl/audio_mix_channel.sv
// One audio channel of the dry/wet mixer: two gain multiplies registered,
// then sum, arithmetic shift and saturation into a holding output register.
module audio_mix_channel
  import audio_pkg::*;
#(
  parameter int unsigned GAIN_W = 7,
  parameter int unsigned SHIFT  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prod_en_i,
  input  logic                       out_en_i,
  input  logic signed [SAMPLE_W-1:0] dry_i,
  input  logic signed [SAMPLE_W-1:0] wet_i,
  input  logic        [GAIN_W-1:0]   g_dry_i,
  input  logic        [GAIN_W-1:0]   g_wet_i,
  output logic        [SAMPLE_W-1:0] y_o
);

  localparam int unsigned P_W = 24;

  logic signed [P_W-1:0]      pDry_d, pWet_d;
  logic signed [P_W-1:0]      pDry_q, pWet_q;
  logic signed [P_W-1:0]      sum, shifted;
  logic        [SAMPLE_W-1:0] y_d, y_q;

  // Gains are unsigned, so they get a zero sign bit before the signed multiply
  always_comb begin
    pDry_d = P_W'(dry_i) * P_W'($signed({1'b0, g_dry_i}));
    pWet_d = P_W'(wet_i) * P_W'($signed({1'b0, g_wet_i}));
  end

  // Product stage, loaded on the sample strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      pDry_q <= '0;
      pWet_q <= '0;
    end else if (prod_en_i) begin
      pDry_q <= pDry_d;
      pWet_q <= pWet_d;
    end
  end

  // Sum, floor-shift back to sample scale, clamp to the 16-bit signed range
  always_comb begin
    sum     = pDry_q + pWet_q;
    shifted = sum >>> SHIFT;
    if (shifted > 24'sd32767) begin
      y_d = 16'h7FFF;
    end else if (shifted < -24'sd32768) begin
      y_d = 16'h8000;
    end else begin
      y_d = shifted[SAMPLE_W-1:0];
    end
  end

  // Output register holds its value between updates
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else if (out_en_i) begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/audio_route_fader.sv
// Click-free router between ADC (dry), filter (wet) and DAC. Per-source gains
// ramp one step per sample toward the targets of the switch-selected mode;
// mixing uses the gains held before each strobe's update.
module audio_route_fader
  import audio_pkg::*;
#(
  parameter int unsigned RAMP_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  audio_route_fader_if.slave  bus
);

  localparam int unsigned     GW         = RAMP_LOG2 + 1;
  localparam logic [GW-1:0]   RAMP_STEPS = GW'(2 ** RAMP_LOG2);

  mode_e         mode;
  logic [GW-1:0] tgtDry, tgtWet;
  logic [GW-1:0] gDry_d, gDry_q;
  logic [GW-1:0] gWet_d, gWet_q;
  fader_state_e  state_d, state_q;
  logic          vld1_q;
  logic          dacValid_q;
  logic [SAMPLE_W-1:0] yL, yR;

  function automatic logic [GW-1:0] step_toward(input logic [GW-1:0] g,
                                                input logic [GW-1:0] t);
    if (g < t)      return g + GW'(1);
    else if (g > t) return g - GW'(1);
    else            return g;
  endfunction

  // Mode decode and gain targets from the current switch levels
  always_comb begin
    mode   = decode_mode({bus.sw1, bus.sw0});
    tgtDry = (mode == MODE_DRY) ? RAMP_STEPS : '0;
    tgtWet = (mode == MODE_WET) ? RAMP_STEPS : '0;
  end

  // Gain ramp and fader state advance only on a sample strobe
  always_comb begin
    gDry_d  = gDry_q;
    gWet_d  = gWet_q;
    state_d = state_q;
    if (bus.sampleValid) begin
      gDry_d = step_toward(gDry_q, tgtDry);
      gWet_d = step_toward(gWet_q, tgtWet);
      if (gDry_d == tgtDry && gWet_d == tgtWet) begin
        case (mode)
          MODE_DRY: state_d = STEADY_DRY;
          MODE_WET: state_d = STEADY_WET;
          default:  state_d = STEADY_MUTE;
        endcase
      end else begin
        state_d = FADING;
      end
    end
  end

  // Gain, state and valid-pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gDry_q     <= '0;
      gWet_q     <= '0;
      state_q    <= STEADY_MUTE;
      vld1_q     <= 1'b0;
      dacValid_q <= 1'b0;
    end else begin
      gDry_q     <= gDry_d;
      gWet_q     <= gWet_d;
      state_q    <= state_d;
      vld1_q     <= bus.sampleValid;
      dacValid_q <= vld1_q;
    end
  end

  audio_mix_channel #(.GAIN_W(GW), .SHIFT(RAMP_LOG2)) u_mix_l (
    .clk       (clk),
    .rst       (rst),
    .prod_en_i (bus.sampleValid),
    .out_en_i  (vld1_q),
    .dry_i     (bus.dryIn[L_HI:L_LO]),
    .wet_i     (bus.wetIn[L_HI:L_LO]),
    .g_dry_i   (gDry_q),
    .g_wet_i   (gWet_q),
    .y_o       (yL)
  );

  audio_mix_channel #(.GAIN_W(GW), .SHIFT(RAMP_LOG2)) u_mix_r (
    .clk       (clk),
    .rst       (rst),
    .prod_en_i (bus.sampleValid),
    .out_en_i  (vld1_q),
    .dry_i     (bus.dryIn[R_HI:R_LO]),
    .wet_i     (bus.wetIn[R_HI:R_LO]),
    .g_dry_i   (gDry_q),
    .g_wet_i   (gWet_q),
    .y_o       (yR)
  );

  assign bus.dacOut   = {yL, yR};
  assign bus.dacValid = dacValid_q;
  assign bus.fadeBusy = (state_q == FADING);

endmodule

// File: tb/tb_audio_route_fader.sv
// Directed + randomized bench for audio_route_fader with an arithmetic
// reference model of the gain ramp and mix.
module tb_audio_route_fader;

  localparam int STEPS = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  audio_route_fader_if bus ();

  audio_route_fader #(.RAMP_LOG2(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests  = 0;
  int failed = 0;
  int gd = 0;
  int gw = 0;
  logic [31:0] last_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mix_ch(input int xd, input int xw, input int a, input int b);
    int p, y;
    p = xd * a + xw * b;
    if (p >= 0) y = p / STEPS;
    else        y = -((-p + STEPS - 1) / STEPS);
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  function automatic logic [31:0] model_mix(input logic [31:0] d, input logic [31:0] w);
    int l, r;
    l = mix_ch(int'($signed(d[31:16])), int'($signed(w[31:16])), gd, gw);
    r = mix_ch(int'($signed(d[15:0])),  int'($signed(w[15:0])),  gd, gw);
    return {16'(l), 16'(r)};
  endfunction

  function automatic int toward(input int g, input int t);
    if (g < t) return g + 1;
    if (g > t) return g - 1;
    return g;
  endfunction

  // One strobe; checks busy/gains at T+1 and the mixed output at T+2
  task automatic strobe(input logic [1:0] sw, input logic [31:0] d,
                        input logic [31:0] w, output logic [31:0] got);
    logic [31:0] exp;
    int td, tw;
    logic busy;
    @(negedge clk);
    bus.sw1 = sw[1]; bus.sw0 = sw[0];
    bus.dryIn = d; bus.wetIn = w;
    bus.sampleValid = 1'b1;
    exp = model_mix(d, w);
    td = (sw == 2'b01) ? STEPS : 0;
    tw = (sw == 2'b11) ? STEPS : 0;
    gd = toward(gd, td);
    gw = toward(gw, tw);
    busy = (gd != td) || (gw != tw);
    @(negedge clk);
    bus.sampleValid = 1'b0;
    chk("busy", {31'b0, bus.fadeBusy}, {31'b0, busy});
    chk("gdry", 32'(dut.gDry_q), 32'(gd));
    chk("gwet", 32'(dut.gWet_q), 32'(gw));
    chk("valid_early", {31'b0, bus.dacValid}, 32'd0);
    @(negedge clk);
    chk("valid", {31'b0, bus.dacValid}, 32'd1);
    chk("dacOut", bus.dacOut, exp);
    got = bus.dacOut;
    last_out = exp;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_valid", {31'b0, bus.dacValid}, 32'd0);
      chk("idle_hold", bus.dacOut, last_out);
    end
  endtask

  function automatic int absdiff16(input logic [15:0] a, input logic [15:0] b);
    int x;
    x = int'($signed(a)) - int'($signed(b));
    return (x < 0) ? -x : x;
  endfunction

  initial begin
    logic [31:0] got, prev;
    bus.sampleValid = 1'b0;
    bus.dryIn = '0; bus.wetIn = '0;
    bus.sw0 = 1'b0; bus.sw1 = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out",   bus.dacOut, 32'd0);
    chk("rst_valid", {31'b0, bus.dacValid}, 32'd0);
    chk("rst_busy",  {31'b0, bus.fadeBusy}, 32'd0);
    chk("rst_gdry",  32'(dut.gDry_q), 32'd0);

    // MUTE -> DRY fade-in with a fixed dry sample
    for (int i = 1; i <= 70; i++) begin
      strobe(2'b01, 32'h1000_F000, $urandom, got);
      if (i == 1)  chk("dry_first",  got, 32'h0000_0000);
      if (i == 2)  chk("dry_second", got, 32'h0040_FFC0);
      if (i >= 65) chk("dry_full",   got, 32'h1000_F000);
      if (i == 63) chk("busy_before_end", {31'b0, bus.fadeBusy}, 32'd1);
      if (i == 64) chk("busy_fall",       {31'b0, bus.fadeBusy}, 32'd0);
    end

    // DRY -> WET crossfade keeps the gain sum constant
    for (int i = 1; i <= 70; i++) begin
      strobe(2'b11, 32'h0000_0000, 32'h2000_2000, got);
      chk("xfade_sum", 32'(dut.gDry_q) + 32'(dut.gWet_q), 32'd64);
      if (i == 33) chk("xfade_half", got, 32'h1000_1000);
      if (i == 65) chk("xfade_full", got, 32'h2000_2000);
    end

    // Back to DRY with random data
    for (int i = 0; i < 70; i++) strobe(2'b01, $urandom, $urandom, got);

    // DRY -> MUTE for 10 strobes, then reverse; outputs move in small steps
    prev = last_out;
    for (int i = 0; i < 20; i++) begin
      strobe((i < 10) ? 2'b00 : 2'b01, 32'h4000_C000, $urandom, got);
      if (i > 0) begin
        chk("jump_l", {31'b0, absdiff16(got[31:16], prev[31:16]) > 256}, 32'd0);
        chk("jump_r", {31'b0, absdiff16(got[15:0],  prev[15:0])  > 256}, 32'd0);
      end
      prev = got;
      if (i == 9)  chk("mute_dip", 32'(dut.gDry_q), 32'd54);
      if (i == 19) chk("mute_back", 32'(dut.gDry_q), 32'd64);
    end

    // Full-scale extremes at unity gain
    strobe(2'b01, 32'h8000_7FFF, $urandom, got);
    chk("extreme", got, 32'h8000_7FFF);

    // Switch toggles with no strobe have no effect
    @(negedge clk); bus.sw1 = 1'b1; bus.sw0 = 1'b1;
    idle(3);
    bus.sw1 = 1'b0; bus.sw0 = 1'b1;
    idle(2);
    chk("toggle_gdry", 32'(dut.gDry_q), 32'd64);
    chk("toggle_gwet", 32'(dut.gWet_q), 32'd0);
    chk("toggle_busy", {31'b0, bus.fadeBusy}, 32'd0);
    chk("toggle_out",  bus.dacOut, 32'h8000_7FFF);

    // Random modes, data and spacing
    for (int i = 0; i < 150; i++) begin
      strobe(2'($urandom_range(0, 3)), $urandom, $urandom, got);
      idle($urandom_range(0, 3));
    end

    // Reset one cycle after a strobe suppresses the pending output
    @(negedge clk);
    bus.sw1 = 1'b1; bus.sw0 = 1'b1;
    bus.dryIn = $urandom; bus.wetIn = 32'h1234_5678;
    bus.sampleValid = 1'b1;
    @(negedge clk);
    bus.sampleValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gd = 0; gw = 0; last_out = '0;
    chk("midrst_gdry",  32'(dut.gDry_q), 32'd0);
    chk("midrst_gwet",  32'(dut.gWet_q), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(audio_pkg::STEADY_MUTE));
    chk("midrst_busy",  {31'b0, bus.fadeBusy}, 32'd0);
    idle(4);

    // Normal operation resumes after reset
    for (int i = 0; i < 3; i++) strobe(2'b11, $urandom, $urandom, got);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
